// File: rtl/zebra_stripe_stream_detector.sv
// zebra_stripe_stream_detector: classifies rows of a streamed edge frame and reports a crossing verdict per frame
module zebra_stripe_stream_detector #(
  parameter int IMG_WIDTH         = 640,
  parameter int IMG_HEIGHT        = 480,
  parameter int W                 = 8,
  parameter int EDGE_THRESHOLD    = 50,
  parameter int MIN_EDGES_PER_ROW = 80,
  parameter int MIN_STRIPES       = 4,
  parameter int MAX_STRIPES       = 15,
  parameter int ROI_TOP           = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         pixel_valid,
  input  logic         frame_start,
  input  logic [W-1:0] edge_pixel,
  output logic         crossing_detected,
  output logic         detection_valid,
  output logic [7:0]   stripe_count,
  output logic [15:0]  confidence,
  output logic         frame_abort
);
  localparam int XW = IMG_WIDTH > 1 ? $clog2(IMG_WIDTH) : 1;
  localparam int YW = IMG_HEIGHT > 1 ? $clog2(IMG_HEIGHT) : 1;
  localparam int CW = $clog2(IMG_WIDTH + 1);
  localparam logic [1:0] IDLE = 2'd0, ACTIVE = 2'd1, REPORT = 2'd2;
  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);
  localparam logic [YW:0] ROI = (YW + 1)'(ROI_TOP);
  localparam logic [CW-1:0] RC_MAX = CW'(IMG_WIDTH);
  localparam logic [CW-1:0] MIN_E = CW'(MIN_EDGES_PER_ROW);
  logic [1:0] state;
  logic [XW-1:0] x, cx;
  logic [YW-1:0] y, cy;
  logic [CW-1:0] row_cnt, rc_b, rc_n;
  logic [7:0] band_cnt, bc_b, bc_n;
  logic [15:0] srow_cnt, sc_b, sc_n;
  logic in_band, ib_b, ib_n;
  logic resync, start, acc, is_edge, row_end, frame_end, row_stripe;
  // A frame_start anywhere but the expected origin restarts the frame from fresh counters
  always_comb begin
    resync = pixel_valid && frame_start && state == ACTIVE && (x != '0 || y != '0);
    start = pixel_valid && frame_start && (state != ACTIVE || x != '0 || y != '0);
    acc = pixel_valid && (state == ACTIVE || frame_start);
    cx = start ? '0 : x;
    cy = start ? '0 : y;
    rc_b = start ? '0 : row_cnt;
    bc_b = start ? '0 : band_cnt;
    sc_b = start ? '0 : srow_cnt;
    ib_b = start ? 1'b0 : in_band;
    is_edge = edge_pixel > W'(EDGE_THRESHOLD);
    rc_n = rc_b + CW'(is_edge && rc_b != RC_MAX);
    row_end = cx == X_LAST;
    frame_end = row_end && cy == Y_LAST;
    row_stripe = rc_n >= MIN_E && {1'b0, cy} >= ROI;
    bc_n = row_end && row_stripe && !ib_b && bc_b != 8'hFF ? bc_b + 8'd1 : bc_b;
    sc_n = row_end && row_stripe && sc_b != 16'hFFFF ? sc_b + 16'd1 : sc_b;
    ib_n = row_end ? row_stripe : ib_b;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      x <= '0;
      y <= '0;
      row_cnt <= '0;
      band_cnt <= '0;
      srow_cnt <= '0;
      in_band <= 1'b0;
      crossing_detected <= 1'b0;
      detection_valid <= 1'b0;
      stripe_count <= '0;
      confidence <= '0;
      frame_abort <= 1'b0;
    end else begin
      frame_abort <= resync;
      detection_valid <= acc && frame_end;
      if (acc) begin
        x <= row_end ? '0 : cx + 1'b1;
        y <= row_end ? (frame_end ? '0 : cy + 1'b1) : cy;
        row_cnt <= row_end ? '0 : rc_n;
        band_cnt <= frame_end ? '0 : bc_n;
        srow_cnt <= frame_end ? '0 : sc_n;
        in_band <= frame_end ? 1'b0 : ib_n;
        state <= frame_end ? REPORT : ACTIVE;
        if (frame_end) begin
          crossing_detected <= bc_n >= 8'(MIN_STRIPES) && bc_n <= 8'(MAX_STRIPES);
          stripe_count <= bc_n;
          confidence <= sc_n;
        end
      end else if (state == REPORT) begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_zebra_stripe_stream_detector.sv
// tb_zebra_stripe_stream_detector: directed frames with hand-computed verdicts
module tb_zebra_stripe_stream_detector;
  localparam int WD = 16, HT = 12;
  logic clk = 0, rst_n = 0, pixel_valid = 0, frame_start = 0;
  logic [7:0] edge_pixel = 0;
  logic cd, dv, fa, r_cd, r_dv, r_fa;
  logic [7:0] sc, r_sc;
  logic [15:0] conf, r_conf;
  logic [7:0] img [HT][WD];
  int total = 0, passed = 0, dv_cnt = 0, fa_cnt = 0, d0, f0;
  zebra_stripe_stream_detector #(.IMG_WIDTH(WD), .IMG_HEIGHT(HT), .W(8), .EDGE_THRESHOLD(50),
    .MIN_EDGES_PER_ROW(8), .MIN_STRIPES(2), .MAX_STRIPES(4), .ROI_TOP(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .pixel_valid(pixel_valid), .frame_start(frame_start),
    .edge_pixel(edge_pixel), .crossing_detected(cd), .detection_valid(dv),
    .stripe_count(sc), .confidence(conf), .frame_abort(fa));
  zebra_stripe_stream_detector #(.IMG_WIDTH(WD), .IMG_HEIGHT(HT), .W(8), .EDGE_THRESHOLD(50),
    .MIN_EDGES_PER_ROW(8), .MIN_STRIPES(2), .MAX_STRIPES(4), .ROI_TOP(6)) u_roi (
    .clk(clk), .rst_n(rst_n), .pixel_valid(pixel_valid), .frame_start(frame_start),
    .edge_pixel(edge_pixel), .crossing_detected(r_cd), .detection_valid(r_dv),
    .stripe_count(r_sc), .confidence(r_conf), .frame_abort(r_fa));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    dv_cnt <= dv_cnt + int'(dv);
    fa_cnt <= fa_cnt + int'(fa);
  end
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      pixel_valid = 0;
      frame_start = 0;
    end
  endtask
  task automatic send(input int from, input int to, input bit gap, input bit fs);
    for (int i = from; i <= to; i++) begin
      if (gap && $urandom_range(0, 1) == 1) idle(1);
      @(negedge clk);
      pixel_valid = 1;
      frame_start = fs && i == from;
      edge_pixel = img[i / WD][i % WD];
    end
  endtask
  // kind 1: bands at rows 2-3, 6, 9-10; kind 2: threshold rows; kind 3: alternating rows 0-10
  task automatic load(input int kind);
    for (int y = 0; y < HT; y++)
      for (int x = 0; x < WD; x++)
        img[y][x] = kind == 1 ? ((y inside {2, 3, 6, 9, 10} && x < 10) ? 8'd200 : 8'd0) :
                    kind == 2 ? ((y == 3 && x < 8) ? 8'd51 : y == 5 ? (x < 8 ? 8'd50 : x < 15 ? 8'd51 : 8'd0) : 8'd0) :
                    ((y % 2 == 0 && y <= 10) ? 8'd200 : 8'd0);
  endtask
  task automatic report(input string tag, input int e_cd, input int e_sc, input int e_conf);
    idle(1);
    chk({tag, "_dv"}, dv, 1);
    chk({tag, "_cd"}, cd, e_cd);
    chk({tag, "_sc"}, sc, e_sc);
    chk({tag, "_conf"}, conf, e_conf);
    idle(1);
    chk({tag, "_dv_low"}, dv, 0);
    chk({tag, "_sc_hold"}, sc, e_sc);
    idle(2);
  endtask
  initial begin
    load(1);
    #12;
    chk("rst_dv", dv, 0);
    chk("rst_cd", cd, 0);
    chk("rst_sc", sc, 0);
    chk("rst_conf", conf, 0);
    chk("rst_fa", fa, 0);
    @(negedge clk) rst_n = 1;
    d0 = dv_cnt;
    send(0, WD * HT - 1, 0, 1);
    report("s1", 1, 3, 5);
    chk("s1_pulses", dv_cnt - d0, 1);
    load(2);
    send(0, WD * HT - 1, 0, 1);
    report("s2", 0, 1, 1);
    load(3);
    send(0, WD * HT - 1, 0, 1);
    report("s3", 0, 6, 6);
    chk("s3_roi_sc", r_sc, 3);
    chk("s3_roi_cd", r_cd, 1);
    chk("s3_roi_conf", r_conf, 3);
    load(1);
    d0 = dv_cnt;
    send(0, WD * HT - 1, 1, 1);
    report("s4", 1, 3, 5);
    chk("s4_pulses", dv_cnt - d0, 1);
    load(3);
    send(0, WD * HT - 1, 0, 1);
    report("s5_pre", 0, 6, 6);
    load(1);
    d0 = dv_cnt;
    f0 = fa_cnt;
    send(0, 7 * WD + 4, 0, 1);
    send(0, 0, 0, 1);
    idle(1);
    chk("s5_fa", fa, 1);
    chk("s5_sc_held", sc, 6);
    chk("s5_dv", dv, 0);
    idle(1);
    chk("s5_fa_low", fa, 0);
    send(1, WD * HT - 1, 0, 0);
    report("s5", 1, 3, 5);
    chk("s5_pulses", dv_cnt - d0, 1);
    chk("s5_aborts", fa_cnt - f0, 1);
    load(3);
    d0 = dv_cnt;
    send(0, WD * HT - 1, 0, 1);
    send(0, WD * HT - 1, 0, 1);
    report("s6", 0, 6, 6);
    chk("s6_pulses", dv_cnt - d0, 2);
    load(1);
    send(0, 50, 0, 1);
    #2 rst_n = 0;
    #1;
    chk("s6_rst_sc", sc, 0);
    chk("s6_rst_conf", conf, 0);
    chk("s6_rst_cd", cd, 0);
    @(negedge clk) rst_n = 1;
    d0 = dv_cnt;
    send(51, WD * HT - 1, 0, 0);
    idle(4);
    chk("s6_ignored", dv_cnt - d0, 0);
    chk("s6_ignored_sc", sc, 0);
    send(0, WD * HT - 1, 0, 1);
    report("s6_after", 1, 3, 5);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/zebra_stripe_stream_detector.md
Name: zebra_stripe_stream_detector

Overview:
Streaming successor to the frame-buffered zebra crossing detector. It classifies each row of an edge-filtered frame on the fly and stores no frame buffer. Per-row edge counts drive row classification; contiguous stripe rows are grouped into bands, and a crossing verdict is reported once per frame. It sits directly after the convolution/edge filter in the pattern-recognition path.

Parameters:
IMG_WIDTH, 640, pixels per row
IMG_HEIGHT, 480, rows per frame
W, 8, edge pixel width
EDGE_THRESHOLD, 50, pixel counts as edge when strictly greater than this value
MIN_EDGES_PER_ROW, 80, row is a stripe row when its edge count is at least this value
MIN_STRIPES, 4, minimum band count for a crossing
MAX_STRIPES, 15, maximum band count for a crossing
ROI_TOP, 0, rows with y < ROI_TOP are never classified as stripe rows

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
pixel_valid  input  1  edge_pixel is valid this cycle
frame_start  input  1  qualified by pixel_valid; marks pixel (0,0)
edge_pixel  input  W  edge magnitude, raster order
crossing_detected  output  1  verdict for the last completed frame
detection_valid  output  1  one-cycle pulse when a new verdict is loaded
stripe_count  output  8  band count for the last frame, saturating at 255
confidence  output  16  stripe-row count for the last frame, saturating at 0xFFFF
frame_abort  output  1  one-cycle pulse when a frame is abandoned by resync

Behaviour:
- Reset (async, rst_n low): state IDLE; x, y, row count, band count, row-stripe count, and in_band all 0; all outputs 0.
- States and transitions:
  - IDLE: ignores pixels unless pixel_valid && frame_start. That pixel is accepted as (0,0); go to ACTIVE.
  - ACTIVE: every pixel_valid cycle accepts one pixel at (x,y). x wraps at IMG_WIDTH-1 and y then increments. The last pixel (IMG_WIDTH-1, IMG_HEIGHT-1) moves to REPORT.
  - REPORT: lasts exactly one cycle. If pixel_valid && frame_start occurs in this cycle, that pixel is accepted as (0,0) of the next frame and the state goes to ACTIVE. Otherwise the state returns to IDLE and any pixel without frame_start is dropped.
- Edge test: edge_pixel > EDGE_THRESHOLD (strict, unsigned). The row edge counter is $clog2(IMG_WIDTH+1) bits and saturates at IMG_WIDTH.
- Row close, on the accepted pixel with x == IMG_WIDTH-1:
  - row_stripe = (row count including this pixel >= MIN_EDGES_PER_ROW) && (y >= ROI_TOP).
  - If row_stripe && !in_band: band count +1, saturating at 255.
  - If row_stripe: stripe-row count +1, saturating at 0xFFFF.
  - in_band <= row_stripe. The row counter clears to 0.
- Resync: frame_start with pixel_valid in ACTIVE at any position other than (0,0) abandons the current frame.
  - frame_abort pulses 1 cycle later.
  - All per-frame counters and in_band clear, and this pixel becomes (0,0) of the new frame.
  - No verdict is produced for the abandoned frame; outputs hold their previous values.
- frame_start on the expected (0,0) pixel in ACTIVE cannot occur. That position is only reached from IDLE or REPORT. The bench checks it is harmless.
- Report, registered on entry to REPORT (1 cycle after the last pixel is accepted):
  - detection_valid = 1 for that single cycle.
  - crossing_detected = (MIN_STRIPES <= band count <= MAX_STRIPES).
  - stripe_count and confidence are loaded from the final counts, which include the last row.
  - The outputs hold until the next report or reset. Per-frame counters clear for the next frame.
- pixel_valid gaps are allowed anywhere. Position and counters hold while pixel_valid is low.
- Reset asserted mid-frame: immediate return to reset values, with no report and no frame_abort pulse.

Test Plan:
All scenarios use IMG_WIDTH=16, IMG_HEIGHT=12, EDGE_THRESHOLD=50, MIN_EDGES_PER_ROW=8, MIN_STRIPES=2, MAX_STRIPES=4, ROI_TOP=0.

1. Three bands: rows 2-3, 6, and 9-10 have 10 pixels=200 each, all other pixels=0 -> detection_valid pulses 1 cycle after the last pixel; crossing_detected=1, stripe_count=3, confidence=5.
2. Threshold edges: one row with 8 pixels=51, another row with 8 pixels=50 and 7 pixels=51, rest 0 -> first row is stripe, second is not; stripe_count=1, crossing_detected=0, confidence=1.
3. Too many bands: alternating stripe/blank rows 0-10 (6 bands) -> stripe_count=6, crossing_detected=0. Then ROI_TOP=6 on the same image -> stripe_count=3, crossing_detected=1.
4. Random pixel_valid gaps (~50% duty) on scenario 1's image -> identical outputs; exactly one detection_valid pulse.
5. frame_start reasserted at (5,7) mid-frame -> frame_abort pulse, no detection_valid. The following full frame from scenario 1 reports stripe_count=3.
6. Back-to-back frames with frame_start in the REPORT cycle -> no pixel dropped, two detection_valid pulses. rst_n low mid-frame -> all outputs 0 asynchronously; pixels ignored until the next frame_start.
